// File: rtl/rv_p4_pkg.sv
// Shared constants and types for the header parser.
package rv_p4_pkg;

  localparam int PARSER_HDR_BYTES = 64;
  localparam int PARSER_HDR_BITS  = PARSER_HDR_BYTES * 8;
  localparam int PARSER_MAX_STEPS = 16;

  localparam logic [5:0] PARSER_ST_ACCEPT = 6'd63;
  localparam logic [5:0] PARSER_ST_REJECT = 6'd62;

  typedef enum logic [2:0] {
    PS_ACCEPT = 3'd0,
    PS_REJECT = 3'd1,
    PS_MISS   = 3'd2,
    PS_TRUNC  = 3'd3,
    PS_LOOP   = 3'd4
  } parser_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_EXTRACT,
    S_ADVANCE,
    S_DONE
  } parser_fsm_state_e;

  // Bytes carried by a PHV beat given the bytes still left to extract.
  function automatic logic [3:0] beat_len(input logic [7:0] rem);
    return (rem > 8'd8) ? 4'd8 : rem[3:0];
  endfunction

endpackage

// File: rtl/parser_byte_sel.sv
// Picks an 8-byte big-endian window out of the header buffer; bytes past the
// valid length or the buffer end read as zero.
module parser_byte_sel
  import rv_p4_pkg::*;
(
  input  logic [PARSER_HDR_BITS-1:0] hdr,
  input  logic [7:0]                 hdr_len,
  input  logic [7:0]                 offset,
  output logic [63:0]                window
);

  logic [7:0] hdr_byte [PARSER_HDR_BYTES];
  logic [8:0] idx;

  always_comb begin
    for (int b = 0; b < PARSER_HDR_BYTES; b++) begin
      hdr_byte[b] = hdr[PARSER_HDR_BITS-1-8*b -: 8];
    end
  end

  always_comb begin
    window = '0;
    idx    = '0;
    for (int i = 0; i < 8; i++) begin
      idx = {1'b0, offset} + 9'(i);
      if (idx < 9'(PARSER_HDR_BYTES) && idx < {1'b0, hdr_len}) begin
        window[63-8*i -: 8] = hdr_byte[idx[5:0]];
      end
    end
  end

endmodule

// File: rtl/parser_fsm.sv
// Programmable header parser: walks TCAM-driven parse states over a latched
// header, emitting PHV byte writes and a final status/header-length result.
//
// state   | meaning
// IDLE    | ready for a new header
// LOOKUP  | TCAM request held until accepted
// WAIT    | TCAM result cycle, result latched
// EXTRACT | one PHV write beat per cycle
// ADVANCE | move header pointer, pick next state or finish
// DONE    | result held until done_ready
module parser_fsm
  import rv_p4_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [PARSER_HDR_BITS-1:0] pkt_hdr,
  input  logic [7:0]                 pkt_len,
  output logic [5:0]                 lookup_state,
  output logic [63:0]                lookup_window,
  output logic                       lookup_valid,
  input  logic                       lookup_ready,
  input  logic                       tcam_hit,
  input  logic [5:0]                 tcam_next_state,
  input  logic [7:0]                 tcam_extract_offset,
  input  logic [7:0]                 tcam_extract_len,
  input  logic [9:0]                 tcam_phv_dst_offset,
  input  logic [7:0]                 tcam_hdr_advance,
  output logic                       phv_wr_en,
  output logic [9:0]                 phv_wr_offset,
  output logic [63:0]                phv_wr_data,
  output logic [3:0]                 phv_wr_len,
  output logic                       done_valid,
  input  logic                       done_ready,
  output logic [2:0]                 done_status,
  output logic [7:0]                 done_hdr_len
);

  parser_fsm_state_e state;

  logic [PARSER_HDR_BITS-1:0] hdr_q;
  logic [7:0]  len_q;
  logic [5:0]  cur_state;
  logic [7:0]  ptr;
  logic [4:0]  step;

  logic [5:0]  t_next;
  logic [7:0]  t_ext_off;
  logic [7:0]  t_ext_len;
  logic [9:0]  t_dst;
  logic [7:0]  t_adv;

  logic [9:0]  ext_ptr;
  logic [7:0]  ext_rem;
  logic [9:0]  phv_dst;
  logic [3:0]  wr_len;

  logic [8:0]  adv_sum;
  logic [4:0]  step_nxt;
  logic [7:0]  ext_sel_off;
  logic [63:0] lookup_win;
  logic [63:0] extract_win;

  assign adv_sum  = {1'b0, ptr} + {1'b0, t_adv};
  assign step_nxt = step + 5'd1;
  // Anything past byte 255 is outside the buffer anyway, so saturate.
  assign ext_sel_off = (ext_ptr > 10'd255) ? 8'hFF : ext_ptr[7:0];

  parser_byte_sel u_lookup_sel (
    .hdr     (hdr_q),
    .hdr_len (len_q),
    .offset  (ptr),
    .window  (lookup_win)
  );

  parser_byte_sel u_extract_sel (
    .hdr     (hdr_q),
    .hdr_len (len_q),
    .offset  (ext_sel_off),
    .window  (extract_win)
  );

  assign lookup_state  = lookup_valid ? cur_state : '0;
  assign lookup_window = lookup_valid ? lookup_win : '0;
  assign phv_wr_offset = phv_wr_en ? phv_dst : '0;
  assign phv_wr_data   = phv_wr_en ? extract_win : '0;
  assign phv_wr_len    = phv_wr_en ? wr_len : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hdr_q        <= '0;
      len_q        <= '0;
      cur_state    <= '0;
      ptr          <= '0;
      step         <= '0;
      t_next       <= '0;
      t_ext_off    <= '0;
      t_ext_len    <= '0;
      t_dst        <= '0;
      t_adv        <= '0;
      ext_ptr      <= '0;
      ext_rem      <= '0;
      phv_dst      <= '0;
      wr_len       <= '0;
      pkt_ready    <= 1'b1;
      lookup_valid <= 1'b0;
      phv_wr_en    <= 1'b0;
      done_valid   <= 1'b0;
      done_status  <= PS_ACCEPT;
      done_hdr_len <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pkt_valid) begin
            hdr_q        <= pkt_hdr;
            len_q        <= pkt_len;
            cur_state    <= '0;
            ptr          <= '0;
            step         <= '0;
            pkt_ready    <= 1'b0;
            lookup_valid <= 1'b1;
            state        <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_ready) begin
            lookup_valid <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          t_next    <= tcam_next_state;
          t_ext_off <= tcam_extract_offset;
          t_ext_len <= tcam_extract_len;
          t_dst     <= tcam_phv_dst_offset;
          t_adv     <= tcam_hdr_advance;
          if (!tcam_hit) begin
            done_valid   <= 1'b1;
            done_status  <= PS_MISS;
            done_hdr_len <= ptr;
            state        <= S_DONE;
          end else if (tcam_extract_len != 8'd0) begin
            ext_ptr   <= {2'b00, ptr} + {2'b00, tcam_extract_offset};
            ext_rem   <= tcam_extract_len;
            phv_dst   <= tcam_phv_dst_offset;
            wr_len    <= beat_len(tcam_extract_len);
            phv_wr_en <= 1'b1;
            state     <= S_EXTRACT;
          end else begin
            state <= S_ADVANCE;
          end
        end
        S_EXTRACT: begin
          if (ext_rem <= 8'd8) begin
            phv_wr_en <= 1'b0;
            state     <= S_ADVANCE;
          end else begin
            ext_rem <= ext_rem - 8'd8;
            ext_ptr <= ext_ptr + 10'd8;
            phv_dst <= phv_dst + 10'd8;
            wr_len  <= beat_len(ext_rem - 8'd8);
          end
        end
        S_ADVANCE: begin
          if (adv_sum > {1'b0, len_q}) begin
            done_valid   <= 1'b1;
            done_status  <= PS_TRUNC;
            done_hdr_len <= ptr;
            state        <= S_DONE;
          end else begin
            ptr       <= adv_sum[7:0];
            cur_state <= t_next;
            step      <= step_nxt;
            if (t_next == PARSER_ST_ACCEPT || t_next == PARSER_ST_REJECT) begin
              done_valid   <= 1'b1;
              done_status  <= (t_next == PARSER_ST_ACCEPT) ? PS_ACCEPT : PS_REJECT;
              done_hdr_len <= adv_sum[7:0];
              state        <= S_DONE;
            end else if (step_nxt == 5'(PARSER_MAX_STEPS)) begin
              done_valid   <= 1'b1;
              done_status  <= PS_LOOP;
              done_hdr_len <= adv_sum[7:0];
              state        <= S_DONE;
            end else begin
              lookup_valid <= 1'b1;
              state        <= S_LOOKUP;
            end
          end
        end
        S_DONE: begin
          if (done_ready) begin
            done_valid   <= 1'b0;
            done_status  <= PS_ACCEPT;
            done_hdr_len <= '0;
            pkt_ready    <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_fsm.sv
// Directed bench for parser_fsm with a small behavioural TCAM and PHV monitor.
module tb_parser_fsm;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [511:0] pkt_hdr;
  logic [7:0]   pkt_len;
  logic [5:0]   lookup_state;
  logic [63:0]  lookup_window;
  logic         lookup_valid;
  logic         lookup_ready;
  logic         tcam_hit = 1'b0;
  logic [5:0]   tcam_next_state = '0;
  logic [7:0]   tcam_extract_offset = '0;
  logic [7:0]   tcam_extract_len = '0;
  logic [9:0]   tcam_phv_dst_offset = '0;
  logic [7:0]   tcam_hdr_advance = '0;
  logic         phv_wr_en;
  logic [9:0]   phv_wr_offset;
  logic [63:0]  phv_wr_data;
  logic [3:0]   phv_wr_len;
  logic         done_valid;
  logic         done_ready;
  logic [2:0]   done_status;
  logic [7:0]   done_hdr_len;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int lookup_cnt = 0;

  localparam int M_EMPTY = 0;
  localparam int M_ETH = 1;
  localparam int M_LOOP = 2;
  localparam int M_TRUNC_ACC = 3;
  localparam int M_REJECT = 4;

  typedef struct {
    logic [9:0]  off;
    logic [3:0]  len;
    logic [63:0] data;
  } beat_t;
  beat_t beats[$];

  parser_fsm dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pkt_valid           (pkt_valid),
    .pkt_ready           (pkt_ready),
    .pkt_hdr             (pkt_hdr),
    .pkt_len             (pkt_len),
    .lookup_state        (lookup_state),
    .lookup_window       (lookup_window),
    .lookup_valid        (lookup_valid),
    .lookup_ready        (lookup_ready),
    .tcam_hit            (tcam_hit),
    .tcam_next_state     (tcam_next_state),
    .tcam_extract_offset (tcam_extract_offset),
    .tcam_extract_len    (tcam_extract_len),
    .tcam_phv_dst_offset (tcam_phv_dst_offset),
    .tcam_hdr_advance    (tcam_hdr_advance),
    .phv_wr_en           (phv_wr_en),
    .phv_wr_offset       (phv_wr_offset),
    .phv_wr_data         (phv_wr_data),
    .phv_wr_len          (phv_wr_len),
    .done_valid          (done_valid),
    .done_ready          (done_ready),
    .done_status         (done_status),
    .done_hdr_len        (done_hdr_len)
  );

  always #5 clk = ~clk;

  // TCAM model: a request seen before an edge gets its result one cycle later.
  always begin
    logic       req;
    logic [5:0] st;
    @(negedge clk);
    req = lookup_valid && lookup_ready;
    st  = lookup_state;
    if (req) lookup_cnt++;
    @(posedge clk);
    #1;
    tcam_hit = 1'b0;
    tcam_next_state = '0;
    tcam_extract_offset = '0;
    tcam_extract_len = '0;
    tcam_phv_dst_offset = '0;
    tcam_hdr_advance = '0;
    if (req) begin
      case (mode)
        M_ETH: begin
          if (st == 6'd0) begin
            tcam_hit = 1'b1; tcam_next_state = 6'd1; tcam_extract_len = 8'd14;
            tcam_phv_dst_offset = 10'd0; tcam_hdr_advance = 8'd14;
          end else if (st == 6'd1) begin
            tcam_hit = 1'b1; tcam_next_state = 6'd63; tcam_extract_len = 8'd20;
            tcam_phv_dst_offset = 10'd14; tcam_hdr_advance = 8'd20;
          end
        end
        M_LOOP: if (st == 6'd0) tcam_hit = 1'b1;
        M_TRUNC_ACC: if (st == 6'd0) begin
          tcam_hit = 1'b1; tcam_next_state = 6'd63; tcam_hdr_advance = 8'd14;
        end
        M_REJECT: if (st == 6'd0) begin
          tcam_hit = 1'b1; tcam_next_state = 6'd62; tcam_hdr_advance = 8'd4;
        end
        default: tcam_hit = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (phv_wr_en) beats.push_back('{phv_wr_offset, phv_wr_len, phv_wr_data});
  end

  function automatic logic [511:0] make_hdr();
    logic [511:0] h = '0;
    for (int i = 0; i < 64; i++) h[511-8*i -: 8] = 8'(i + 1);
    h[511-8*12 -: 8] = 8'h08;
    h[511-8*13 -: 8] = 8'h00;
    return h;
  endfunction

  function automatic logic [63:0] exp_window(input logic [511:0] h, input int len, input int start);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      int idx = start + i;
      if (idx < len && idx < 64) w[63-8*i -: 8] = h[511-8*idx -: 8];
    end
    return w;
  endfunction

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input int n);
    logic [63:0] m = '0;
    for (int i = 0; i < n && i < 8; i++) m[63-8*i -: 8] = 8'hFF;
    return d & m;
  endfunction

  task automatic send_pkt(input logic [511:0] h, input logic [7:0] len);
    @(negedge clk);
    pkt_hdr = h;
    pkt_len = len;
    pkt_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (pkt_ready) break;
      @(negedge clk);
    end
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_pkt_ready: got %b expected 1", pkt_ready);
    end
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic [2:0] st, output logic [7:0] hl);
    logic ok = 1'b0;
    st = 'x;
    hl = 'x;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done_valid) begin
        st = done_status;
        hl = done_hdr_len;
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: no done_valid within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pkt_valid = 1'b0;
    pkt_hdr = '0;
    pkt_len = '0;
    lookup_ready = 1'b1;
    done_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_pkt_ready: got %b expected 1", pkt_ready); end
    checks++;
    if ({lookup_valid, phv_wr_en, done_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b expected 000", {lookup_valid, phv_wr_en, done_valid});
    end
    checks++;
    if ({done_status, done_hdr_len, lookup_state} !== '0) begin
      errors++; $display("FAIL reset_done_fields: status %0d hdr_len %0d lstate %0d expected 0", done_status, done_hdr_len, lookup_state);
    end
    checks++;
    if ({lookup_window, phv_wr_data, phv_wr_offset, phv_wr_len} !== '0) begin
      errors++; $display("FAIL reset_data: window %h data %h expected 0", lookup_window, phv_wr_data);
    end
  endtask

  task automatic test_eth_ipv4(input string tag);
    int exp_off[5] = '{0, 8, 14, 22, 30};
    int exp_len[5] = '{8, 6, 8, 8, 4};
    logic [511:0] h = make_hdr();
    logic [2:0] st;
    logic [7:0] hl;
    mode = M_ETH;
    beats.delete();
    lookup_cnt = 0;
    send_pkt(h, 8'd34);
    wait_done(200, st, hl);
    checks++;
    if (st !== 3'd0 || hl !== 8'd34) begin
      errors++; $display("FAIL %s_done: status %0d hdr_len %0d expected 0 34", tag, st, hl);
    end
    checks++;
    if (lookup_cnt != 2) begin errors++; $display("FAIL %s_lookups: got %0d expected 2", tag, lookup_cnt); end
    checks++;
    if (beats.size() != 5) begin
      errors++; $display("FAIL %s_beat_count: got %0d expected 5", tag, beats.size());
    end else begin
      for (int b = 0; b < 5; b++) begin
        logic [63:0] ed = mask_bytes(exp_window(h, 34, exp_off[b]), exp_len[b]);
        logic [63:0] ad = mask_bytes(beats[b].data, exp_len[b]);
        checks++;
        if (beats[b].off !== 10'(exp_off[b]) || beats[b].len !== 4'(exp_len[b]) || ad !== ed) begin
          errors++;
          $display("FAIL %s_beat%0d: off %0d len %0d data %h expected %0d %0d %h", tag, b,
                   beats[b].off, beats[b].len, ad, exp_off[b], exp_len[b], ed);
        end
      end
    end
  endtask

  task automatic test_miss();
    logic [2:0] st;
    logic [7:0] hl;
    mode = M_EMPTY;
    beats.delete();
    lookup_cnt = 0;
    send_pkt(make_hdr(), 8'd34);
    wait_done(50, st, hl);
    checks++;
    if (st !== 3'd2 || hl !== 8'd0) begin errors++; $display("FAIL miss_done: status %0d hdr_len %0d expected 2 0", st, hl); end
    checks++;
    if (lookup_cnt != 1 || beats.size() != 0) begin
      errors++; $display("FAIL miss_activity: lookups %0d beats %0d expected 1 0", lookup_cnt, beats.size());
    end
  endtask

  task automatic test_trunc();
    logic [511:0] h = make_hdr();
    logic [2:0] st;
    logic [7:0] hl;
    logic [63:0] ed;
    mode = M_ETH;
    beats.delete();
    send_pkt(h, 8'd10);
    wait_done(50, st, hl);
    checks++;
    if (st !== 3'd3 || hl !== 8'd0) begin errors++; $display("FAIL trunc_done: status %0d hdr_len %0d expected 3 0", st, hl); end
    checks++;
    if (beats.size() != 2) begin
      errors++; $display("FAIL trunc_beats: got %0d expected 2", beats.size());
    end else begin
      // second beat: bytes 8,9 present, 10..13 past pkt_len read as zero
      ed = 64'h090A_0000_0000_0000;
      checks++;
      if (beats[1].off !== 10'd8 || beats[1].len !== 4'd6 || mask_bytes(beats[1].data, 6) !== ed) begin
        errors++; $display("FAIL trunc_beat1: off %0d len %0d data %h expected 8 6 %h",
                           beats[1].off, beats[1].len, mask_bytes(beats[1].data, 6), ed);
      end
    end
  endtask

  task automatic test_loop();
    logic [2:0] st;
    logic [7:0] hl;
    mode = M_LOOP;
    beats.delete();
    lookup_cnt = 0;
    send_pkt(make_hdr(), 8'd20);
    wait_done(200, st, hl);
    checks++;
    if (st !== 3'd4 || hl !== 8'd0) begin errors++; $display("FAIL loop_done: status %0d hdr_len %0d expected 4 0", st, hl); end
    checks++;
    if (lookup_cnt != 16 || beats.size() != 0) begin
      errors++; $display("FAIL loop_activity: lookups %0d beats %0d expected 16 0", lookup_cnt, beats.size());
    end
  endtask

  task automatic test_priority();
    logic [2:0] st;
    logic [7:0] hl;
    mode = M_TRUNC_ACC;
    send_pkt(make_hdr(), 8'd10);
    wait_done(50, st, hl);
    checks++;
    if (st !== 3'd3 || hl !== 8'd0) begin errors++; $display("FAIL trunc_over_accept: status %0d hdr_len %0d expected 3 0", st, hl); end
    mode = M_REJECT;
    send_pkt(make_hdr(), 8'd10);
    wait_done(50, st, hl);
    checks++;
    if (st !== 3'd1 || hl !== 8'd4) begin errors++; $display("FAIL reject_done: status %0d hdr_len %0d expected 1 4", st, hl); end
  endtask

  task automatic test_stall();
    logic [511:0] h = make_hdr();
    logic [63:0] ew = exp_window(h, 34, 0);
    logic [2:0] st;
    logic [7:0] hl;
    mode = M_EMPTY;
    lookup_cnt = 0;
    lookup_ready = 1'b0;
    send_pkt(h, 8'd34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (lookup_valid !== 1'b1 || lookup_window !== ew || lookup_state !== 6'd0) begin
        errors++; $display("FAIL stall_lookup%0d: valid %b window %h state %0d expected 1 %h 0",
                           k, lookup_valid, lookup_window, lookup_state, ew);
      end
    end
    done_ready = 1'b0;
    lookup_ready = 1'b1;
    wait_done(20, st, hl);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (done_valid !== 1'b1 || done_status !== 3'd2 || done_hdr_len !== 8'd0 || pkt_ready !== 1'b0) begin
        errors++; $display("FAIL stall_done%0d: valid %b status %0d hdr_len %0d pkt_ready %b expected 1 2 0 0",
                           k, done_valid, done_status, done_hdr_len, pkt_ready);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done_valid !== 1'b0 || pkt_ready !== 1'b1 || lookup_cnt != 1) begin
      errors++; $display("FAIL stall_release: done_valid %b pkt_ready %b lookups %0d expected 0 1 1",
                         done_valid, pkt_ready, lookup_cnt);
    end
  endtask

  task automatic test_reset_mid_extract();
    logic seen = 1'b0;
    logic done_seen = 1'b0;
    mode = M_ETH;
    send_pkt(make_hdr(), 8'd34);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (phv_wr_en) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_extract_reach: phv_wr_en never seen, expected 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pkt_ready !== 1'b1 || phv_wr_en !== 1'b0 || lookup_valid !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: pkt_ready %b phv_wr_en %b lookup_valid %b done_valid %b expected 1 0 0 0",
                         pkt_ready, phv_wr_en, lookup_valid, done_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done_valid) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL rst_mid_no_done: done_valid seen 1 expected 0"); end
    test_eth_ipv4("after_rst");
  endtask

  initial begin
    test_reset();
    test_eth_ipv4("eth_ipv4");
    test_miss();
    test_trunc();
    test_loop();
    test_priority();
    test_stall();
    test_reset_mid_extract();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parser_fsm.md
PARSER_FSM -- requirements
Module: parser_fsm

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 pkt_valid / pkt_ready  input / output  1 / 1  header-ingress handshake; a transfer occurs when both are high on a clock edge.
REQ-004 pkt_hdr  input  PARSER_HDR_BYTES*8  first 64 header bytes; byte 0 occupies the MSBs.
REQ-005 pkt_len  input  8  valid header bytes, 0-64.
REQ-006 lookup_state / lookup_window / lookup_valid  output  6 / 64 / 1  parser TCAM lookup request.
REQ-007 lookup_ready  input  1  TCAM can accept a request.
REQ-008 tcam_hit / tcam_next_state / tcam_extract_offset / tcam_extract_len / tcam_phv_dst_offset / tcam_hdr_advance  input  1 / 6 / 8 / 8 / 10 / 8  TCAM result, registered and valid exactly 1 cycle after the request.
REQ-009 phv_wr_en / phv_wr_offset / phv_wr_data / phv_wr_len  output  1 / 10 / 64 / 4  PHV byte-write beat, 1-8 bytes, left-justified.
REQ-010 done_valid / done_ready  output / input  1 / 1  parse-result handshake.
REQ-011 done_status / done_hdr_len  output  3 / 8  parser_status_e result code and final header pointer.

Function
REQ-012 FSM states are IDLE, LOOKUP, WAIT, EXTRACT, ADVANCE and DONE.
REQ-013 pkt_ready SHALL be 1 only in IDLE.
  - On transfer: latch pkt_hdr and pkt_len; cur_state=0, ptr=0, step=0; go to LOOKUP.
REQ-014 LOOKUP SHALL hold lookup_valid=1, lookup_state=cur_state and lookup_window=hdr[ptr..ptr+7], big-endian.
  - Bytes at index >= pkt_len or >= 64 read as 0x00.
  - Advance to WAIT on the first edge where lookup_ready=1.
REQ-015 WAIT lasts exactly 1 cycle and latches all tcam_* fields.
  - tcam_hit=0: status MISS, go to DONE.
  - Else, extract_len>0: go to EXTRACT.
  - Else: go to ADVANCE.
REQ-016 EXTRACT emits one beat per cycle, ceil(extract_len/8) beats in total.
  - Beat b: phv_wr_offset = phv_dst_offset + 8*b, truncated to 10b.
  - Beat b: phv_wr_data = hdr[ptr+extract_offset+8b ..], out-of-range bytes 0x00.
  - Beat b: phv_wr_len = min(8, remaining).
  - After the last beat, go to ADVANCE.
REQ-017 ADVANCE computes ptr+hdr_advance at 9-bit width.
  - Sum > pkt_len: status TRUNC, go to DONE.
  - Else: ptr=sum, cur_state=next_state, step++.
  - next_state==PARSER_ST_ACCEPT (63): status ACCEPT, go to DONE.
  - next_state==PARSER_ST_REJECT (62): status REJECT, go to DONE.
  - step reaches PARSER_MAX_STEPS (16): status LOOP, go to DONE.
  - Otherwise: go to LOOKUP.
REQ-018 Check priority in ADVANCE SHALL be TRUNC > ACCEPT/REJECT > LOOP.
REQ-019 DONE holds done_valid=1, done_status and done_hdr_len=ptr stable until done_ready=1, then returns to IDLE.
  - The same-cycle done_ready handshake completes in 1 cycle.
REQ-020 lookup_valid SHALL be 0 outside LOOKUP; phv_wr_en SHALL be 0 outside EXTRACT.
REQ-021 Minimum cost per parse step is 3 cycles: LOOKUP, WAIT, ADVANCE, plus any EXTRACT beats.

Reset
REQ-022 Asynchronous assertion of rst_n SHALL force IDLE.
  - All outputs go to 0, except pkt_ready=1.
  - Internal ptr, step, cur_state and latched fields go to 0.
REQ-023 Reset mid-parse SHALL abort with no done_valid pulse; in-flight PHV beats are discarded.

Structure
REQ-024 rv_p4_pkg SHALL hold:
  - PARSER_HDR_BYTES=64, PARSER_MAX_STEPS=16, PARSER_ST_ACCEPT=6'd63, PARSER_ST_REJECT=6'd62.
  - parser_status_e: ACCEPT=0, REJECT=1, MISS=2, TRUNC=3, LOOP=4.
REQ-025 A sub-module parser_byte_sel (64-byte buffer, 8-bit offset, 8-byte zero-filled window) SHALL be instantiated twice: once for the lookup window, once for the extract window.

Verification
REQ-026 Eth→IPv4 program, pkt_len=34:
  - Entry (st0, bytes12-13=0x0800) → st1, extract 14B to PHV 0, advance 14.
  - st1 → ACCEPT, extract 20B to PHV 14, advance 20.
  - Required: beats (0,8),(8,6),(14,8),(22,8),(30,4); done ACCEPT, hdr_len=34.
REQ-027 Empty TCAM, any packet → exactly one lookup, no PHV writes; done MISS, hdr_len=0.
REQ-028 pkt_len=10, entry advance 14 → done TRUNC, hdr_len=0; the 14B extraction beats still emitted.
REQ-029 Self-loop entry st0→st0, advance 0 → exactly 16 lookups, then done LOOP.
REQ-030 lookup_ready held low 5 cycles → lookup_valid and lookup_window stable for all 5 cycles.
  - done_ready held low 3 cycles → done outputs stable; pkt_ready=0 until the handshake.
REQ-031 rst_n pulsed low during EXTRACT → outputs 0 and pkt_ready=1 immediately; the next packet parses correctly.
